// File: rtl/mem_burst_master.sv
// Burst master: accepts a read/write burst command and issues one memory request
// per beat (never back-to-back), with a per-request timeout that aborts the burst.
module mem_burst_master #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int ADDRE   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_wr_i,
    input  logic [ADDRE-1:0] cmd_addr_i,
    input  logic [ADDRE:0]   cmd_len_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rdata_valid_o,
    output logic [ADDRE-1:0] addre_o,
    output logic [WIDTH-1:0] write_o,
    output logic             valid_o,
    output logic             wrdata_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] read_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       dbg_state_o
);

    localparam int LW   = ADDRE + 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_REQ   = 3'd2,
        S_GAP   = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_wr;
    logic [ADDRE-1:0] r_addr;
    logic [LW-1:0]    r_len;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_done;
    logic             r_err;
    logic [CNTW-1:0]  r_cnt;

    logic             w_accept;
    logic             w_wtake;
    logic             w_beat;
    logic             w_cnt_full;
    logic             w_timeout;
    logic [ADDRE-1:0] w_addr_inc;

    // Handshakes: a transfer happens on the rising edge where both valid and ready
    // are high (cmd_valid_i/cmd_ready_o, wdata_valid_i/wdata_ready_o, valid_o/ready_i).
    assign w_accept   = (r_state == S_IDLE)  && cmd_valid_i;
    assign w_wtake    = (r_state == S_WDATA) && wdata_valid_i;
    assign w_beat     = (r_state == S_REQ)   && ready_i;
    assign w_cnt_full = (r_cnt == CNTW'(TIMEOUT - 1));
    assign w_timeout  = (r_state == S_REQ) && !ready_i && w_cnt_full;
    assign w_addr_inc = (r_addr == ADDRE'(DEPTH - 1)) ? '0 : r_addr + ADDRE'(1);

    assign addre_o       = r_addr;
    assign write_o       = r_wdata;
    assign wrdata_o      = r_wr;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rvalid;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign dbg_state_o   = r_state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        valid_o       = 1'b0;
        busy_o        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        w_next = S_END;
                    end else if (cmd_wr_i) begin
                        w_next = S_WDATA;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_WDATA: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_next = (r_len == LW'(1)) ? S_END : S_GAP;
                end else if (w_cnt_full) begin
                    w_next = S_IDLE;
                end
            end
            S_GAP:   w_next = r_wr ? S_WDATA : S_REQ;
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // done/err are registered, so they rise in the first IDLE cycle, when busy_o has dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done   <= (r_state == S_END);
            r_err    <= w_timeout;
            r_rvalid <= w_beat && !r_wr;
            if (w_accept) begin
                r_wr   <= cmd_wr_i;
                r_addr <= cmd_addr_i;
                r_len  <= cmd_len_i;
            end
            if (w_wtake) begin
                r_wdata <= wdata_i;
            end
            if (w_beat) begin
                r_addr <= w_addr_inc;
                r_len  <= r_len - LW'(1);
                if (!r_wr) begin
                    r_rdata <= read_i;
                end
            end
            if ((r_state == S_REQ) && !ready_i && !w_timeout) begin
                r_cnt <= r_cnt + CNTW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: memory responder, write-data feeder, negedge monitor
// with expected queues built from burst arithmetic, and a directed/random sequence.
module tb_mem_burst_master;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [7:0]  cmd_addr_i;
    logic [8:0]  cmd_len_i;
    logic [31:0] wdata_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic [7:0]  addre_o;
    logic [31:0] write_o;
    logic        valid_o;
    logic        wrdata_o;
    logic        ready_i;
    logic [31:0] read_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  dbg_state;

    mem_burst_master #(.WIDTH(32), .DEPTH(256), .ADDRE(8), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .addre_o(addre_o), .write_o(write_o), .valid_o(valid_o), .wrdata_o(wrdata_o),
        .ready_i(ready_i), .read_i(read_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_mode = 0;
    int lat_left = 0;
    bit wfeed_rand = 1'b0;
    bit took = 1'b0;

    int acc_cnt = 0, acc_cyc = 0, first_cyc = 0, done_cyc = 0;
    int valid_cycles = 0, beat_cnt = 0, rv_cnt = 0, done_cnt = 0, err_cnt = 0;
    bit first_seen = 1'b0;
    int snap_done, snap_err, snap_valid, snap_beat, snap_acc, snap_rv;

    bit          prev_valid = 1'b0, prev_beat = 1'b0;
    logic [40:0] prev_req;
    logic [40:0] ent;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] bus_mem [DEPTH];
    int          touched [DEPTH];
    logic [40:0] exp_q[$];
    logic [31:0] rexp_q[$];
    logic [31:0] wdata_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory device: mode 0 = ready on the second valid cycle, 1 = random latency, 2 = never ready.
    initial begin : responder
        ready_i = 1'b0;
        read_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i || !valid_o) begin
                ready_i  = (resp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                read_i   = $urandom;
                lat_left = (resp_mode == 1) ? $urandom_range(0, 3) : 1;
            end else if (resp_mode != 2 && lat_left == 0) begin
                ready_i = 1'b1;
                read_i  = bus_mem[addre_o];
            end else begin
                ready_i = 1'b0;
                read_i  = $urandom;
                if (lat_left > 0) lat_left--;
            end
        end
    end

    initial begin : wfeed
        wdata_valid_i = 1'b0;
        wdata_i       = '0;
        forever begin
            @(negedge clk);
            took = wdata_valid_i && wdata_ready_o && !rst_i;
            @(posedge clk);
            #1;
            if (took) begin
                void'(wdata_q.pop_front());
                wdata_valid_i = 1'b0;
            end
            if (!wdata_valid_i && wdata_q.size() > 0 && (!wfeed_rand || $urandom_range(0, 2) == 0)) begin
                wdata_valid_i = 1'b1;
                wdata_i       = wdata_q[0];
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_valid = 1'b0;
                prev_beat  = 1'b0;
            end else begin
                if (cmd_valid_i && cmd_ready_o) begin
                    acc_cnt++;
                    acc_cyc    = cyc;
                    first_seen = 1'b0;
                end
                if (valid_o) begin
                    valid_cycles++;
                    check("busy_during_req", 64'(busy_o), 64'd1);
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_cyc  = cyc;
                    end
                end
                if (prev_beat) check("gap_after_beat", 64'(valid_o), 64'd0);
                if (valid_o && prev_valid && !prev_beat)
                    check("req_stable", 64'({wrdata_o, addre_o, write_o}), 64'(prev_req));
                prev_beat  = valid_o && ready_i;
                prev_valid = valid_o;
                prev_req   = {wrdata_o, addre_o, write_o};
                if (prev_beat) begin
                    beat_cnt++;
                    touched[addre_o]++;
                    check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        ent = exp_q.pop_front();
                        check("req_wr", 64'(wrdata_o), 64'(ent[40]));
                        check("req_addr", 64'(addre_o), 64'(ent[39:32]));
                        if (ent[40]) check("req_wdata", 64'(write_o), 64'(ent[31:0]));
                    end
                    if (wrdata_o) bus_mem[addre_o] = write_o;
                end
                if (rdata_valid_o) begin
                    rv_cnt++;
                    check("rdata_expected", 64'(rexp_q.size() != 0), 64'd1);
                    if (rexp_q.size() != 0) check("rdata", 64'(rdata_o), 64'(rexp_q.pop_front()));
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (err_o) err_cnt++;
            end
        end
    end

    // Reference model: beat k touches (start + k) mod DEPTH.
    task automatic prep(input logic wr, input logic [7:0] addr, input int len);
        logic [7:0]  a;
        logic [31:0] d;
        for (int k = 0; k < len; k++) begin
            a = 8'((int'(addr) + k) % DEPTH);
            if (wr) begin
                d = $urandom;
                wdata_q.push_back(d);
                exp_q.push_back({1'b1, a, d});
                ref_mem[a] = d;
            end else begin
                exp_q.push_back({1'b0, a, 32'h0});
                rexp_q.push_back(ref_mem[a]);
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [8:0] len);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        snap_done = done_cnt; snap_err = err_cnt; snap_valid = valid_cycles;
        snap_beat = beat_cnt; snap_acc = acc_cnt; snap_rv = rv_cnt;
        cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_len_i = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        check("cmd_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'($urandom);
        cmd_addr_i  = 8'($urandom);
        cmd_len_i   = 9'($urandom);
    endtask

    task automatic finish_burst(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_o || err_o) begin
                got = 1'b1;
                break;
            end
        end
        check("burst_end", 64'(got), 64'd1);
        check("done_pulses", 64'(done_cnt - snap_done), 64'd1);
        check("err_pulses", 64'(err_cnt - snap_err), 64'd0);
        check("req_left", 64'(exp_q.size()), 64'd0);
        check("rdata_left", 64'(rexp_q.size()), 64'd0);
        check("busy_at_done", 64'(busy_o), 64'd0);
        @(negedge clk);
        #1;
        check("done_single", 64'(done_o), 64'd0);
    endtask

    initial begin : main
        bit          got;
        bit          wr;
        logic [7:0]  a;
        int          l;
        int          bad;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
            touched[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({busy_o, done_o, err_o, valid_o, wrdata_o, wdata_ready_o, rdata_valid_o, cmd_ready_o}), 64'h01);
        check("rst_addr", 64'(addre_o), 64'd0);
        check("rst_wdata", 64'(write_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_dbg", 64'(dbg_state), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // 64-beat write from 0, then read it back; fixed one-cycle memory latency.
        resp_mode = 0; wfeed_rand = 1'b0;
        prep(1'b1, 8'h00, 64);
        issue(1'b1, 8'h00, 9'd64);
        finish_burst(64 * 8);
        check("wr64_latency", 64'(first_cyc - acc_cyc), 64'd2);
        check("wr64_beats", 64'(beat_cnt - snap_beat), 64'd64);
        check("wr64_valid_cycles", 64'(valid_cycles - snap_valid), 64'd128);

        prep(1'b0, 8'h00, 64);
        issue(1'b0, 8'h00, 9'd64);
        finish_burst(64 * 8);
        check("rd64_latency", 64'(first_cyc - acc_cyc), 64'd1);
        check("rd64_strobes", 64'(rv_cnt - snap_rv), 64'd64);
        check("rd64_valid_cycles", 64'(valid_cycles - snap_valid), 64'd128);

        // Wrapping write FE..01 with a junk command held during the burst.
        resp_mode = 1; wfeed_rand = 1'b1;
        prep(1'b1, 8'hFE, 4);
        issue(1'b1, 8'hFE, 9'd4);
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 8'($urandom); cmd_len_i = 9'd7;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (beat_cnt - snap_beat == 4) begin
                got = 1'b1;
                break;
            end
        end
        check("wrap_beats", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        finish_burst(200);
        check("busy_ignores_cmd", 64'(acc_cnt - snap_acc), 64'd1);
        prep(1'b0, 8'hFE, 4);
        issue(1'b0, 8'hFE, 9'd4);
        finish_burst(200);

        // Zero-length read.
        issue(1'b0, 8'($urandom), 9'd0);
        finish_burst(20);
        check("len0_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
        check("len0_no_valid", 64'(valid_cycles - snap_valid), 64'd0);

        // Timeout with ready_i held low.
        resp_mode = 2;
        issue(1'b0, 8'($urandom), 9'd5);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (err_o || done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("to_end", 64'(got), 64'd1);
        check("to_err_pulse", 64'(err_o), 64'd1);
        check("to_busy", 64'(busy_o), 64'd0);
        check("to_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("to_valid_cycles", 64'(valid_cycles - snap_valid), 64'd16);
        check("to_no_done", 64'(done_cnt - snap_done), 64'd0);
        check("to_no_beats", 64'(beat_cnt - snap_beat), 64'd0);
        @(negedge clk);
        #1;
        check("to_err_single", 64'(err_o), 64'd0);
        check("to_valid_low", 64'(valid_o), 64'd0);

        // Random bursts.
        resp_mode = 1; wfeed_rand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            l  = $urandom_range(0, 24);
            prep(wr, a, l);
            issue(wr, a, 9'(l));
            finish_burst(l * 16 + 40);
        end

        // Full-depth write from a nonzero address touches each address once.
        for (int i = 0; i < DEPTH; i++) touched[i] = 0;
        resp_mode = 0; wfeed_rand = 1'b0;
        prep(1'b1, 8'h37, DEPTH);
        issue(1'b1, 8'h37, 9'd256);
        finish_burst(DEPTH * 8);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (touched[i] != 1) bad++;
        check("depth_touch_once", 64'(bad), 64'd0);
        resp_mode = 1; wfeed_rand = 1'b1;
        prep(1'b0, 8'hC0, DEPTH);
        issue(1'b0, 8'hC0, 9'd256);
        finish_burst(DEPTH * 12);

        // Reset during beat 10 of a 64-beat read.
        resp_mode = 0;
        prep(1'b0, 8'h00, 64);
        issue(1'b0, 8'h00, 9'd64);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (beat_cnt - snap_beat == 9 && valid_o && !ready_i) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_reach_beat10", 64'(got), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(valid_o), 64'd0);
        check("rst_async_busy", 64'(busy_o), 64'd0);
        check("rst_async_rvalid", 64'(rdata_valid_o), 64'd0);
        check("rst_async_cmd_ready", 64'(cmd_ready_o), 64'd1);
        exp_q.delete();
        rexp_q.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt - snap_done), 64'd0);
        check("rst_no_err", 64'(err_cnt - snap_err), 64'd0);
        resp_mode = 1; wfeed_rand = 1'b1;
        a = 8'($urandom);
        prep(1'b1, a, 6);
        issue(1'b1, a, 9'd6);
        finish_burst(200);
        prep(1'b0, a, 6);
        issue(1'b0, a, 9'd6);
        finish_burst(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
